lcd_text_buffer: RTL and testbench

LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

---
 rtl/lcd_text_buffer_if.sv | 23 ++
 rtl/lcd_text_buffer.sv | 84 ++++++++
 tb/tb_lcd_text_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_buffer_if.sv
// lcd_text_buffer_if: byte-write handshake, cell read port and status for the LCD text buffer.
interface lcd_text_buffer_if #(
    parameter int LINE_LEN = 16
);
    localparam int AW = $clog2(2 * LINE_LEN);
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW-1:0] cursor;
    logic          busy;
    logic          dirty;
    logic          dirty_clr;
    modport master (
        output wr_valid, wr_data, rd_addr, dirty_clr,
        input  wr_ready, rd_data, cursor, busy, dirty
    );
    modport slave (
        input  wr_valid, wr_data, rd_addr, dirty_clr,
        output wr_ready, rd_data, cursor, busy, dirty
    );
endinterface

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: two-line character buffer fed by ASCII/control bytes, read combinationally by an LCD driver.
module lcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter int         LINE_LEN  = 16
) (
    input logic              clk,
    input logic              rst,
    lcd_text_buffer_if.slave bus
);
    localparam int CELLS = 2 * LINE_LEN;
    localparam int AW = $clog2(CELLS);
    localparam logic [AW-1:0] LAST = AW'(CELLS - 1);
    localparam logic [AW-1:0] LINE2 = AW'(LINE_LEN);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t        state, state_nxt;
    logic [7:0]    mem [CELLS];
    logic [AW-1:0] cursor, cursor_nxt, sweep, sweep_nxt, wr_idx;
    logic [7:0]    wr_val;
    logic          wr_en, set_dirty, dirty, armed, fire, printable;
    assign fire = bus.wr_valid && bus.wr_ready;
    assign printable = bus.wr_data >= 8'h20 && bus.wr_data <= 8'h7E;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        sweep_nxt  = sweep;
        wr_en      = 1'b0;
        wr_idx     = cursor;
        wr_val     = bus.wr_data;
        set_dirty  = 1'b0;
        if (state == CLEAR) begin
            wr_en     = 1'b1;
            wr_idx    = sweep;
            wr_val    = FILL_CHAR;
            sweep_nxt = sweep + 1'b1;
            if (sweep == LAST) begin
                cursor_nxt = '0;
                set_dirty  = 1'b1;
                state_nxt  = IDLE;
            end
        end else if (fire) begin
            if (printable) begin
                wr_en      = 1'b1;
                set_dirty  = 1'b1;
                cursor_nxt = cursor == LAST ? '0 : cursor + 1'b1;
            end else if (bus.wr_data == 8'h0A) begin
                cursor_nxt = cursor < LINE2 ? LINE2 : '0;
            end else if (bus.wr_data == 8'h08) begin
                // the blank lands on the cell the cursor moves back onto
                cursor_nxt = cursor == '0 ? '0 : cursor - 1'b1;
                wr_en      = 1'b1;
                wr_idx     = cursor_nxt;
                wr_val     = FILL_CHAR;
                set_dirty  = 1'b1;
            end else if (bus.wr_data == 8'h0C) begin
                state_nxt = CLEAR;
                sweep_nxt = '0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= FILL_CHAR;
            cursor <= '0;
            sweep  <= '0;
            dirty  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            armed  <= 1'b1;
            cursor <= cursor_nxt;
            sweep  <= sweep_nxt;
            if (wr_en) mem[wr_idx] <= wr_val;
            dirty  <= set_dirty | (dirty & ~bus.dirty_clr);
        end
    end
    assign bus.wr_ready = armed && state == IDLE;
    assign bus.rd_data  = mem[bus.rd_addr];
    assign bus.cursor   = cursor;
    assign bus.busy     = state == CLEAR;
    assign bus.dirty    = dirty;
endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed stimulus with a queue of expected cell contents drained through the read port.
module tb_lcd_text_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    lcd_text_buffer_if bus ();
    lcd_text_buffer dut (.clk(clk), .rst(rst), .bus(bus));
    int errors = 0;
    int checks = 0;
    typedef struct {
        string      tag;
        logic [4:0] addr;
        logic [7:0] exp;
    } rd_t;
    rd_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int addr, input logic [7:0] exp);
        sb.push_back('{tag, 5'(addr), exp});
    endtask

    task automatic push_all(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 32; i++) push(tag, i, exp);
    endtask

    task automatic drain(input bit on_edge);
        rd_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (on_edge) @(negedge clk);
            bus.rd_addr = e.addr;
            #1;
            chk($sformatf("%s[%0d]", e.tag, e.addr), bus.rd_data, e.exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        #1;
        chk("ready_at_send", bus.wr_ready, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.dirty_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", bus.wr_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", bus.wr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.wr_valid = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_addr = '0;
        bus.dirty_clr = 1'b0;
        // reset state while rst is held
        @(negedge clk);
        chk("rst_cursor", bus.cursor, 0);
        chk("rst_dirty", bus.dirty, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.wr_ready, 0);
        push_all("rst_cell", 8'h20);
        drain(1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_first_edge", bus.wr_ready, 1);

        // "Hi" streamed with wr_valid held
        send(8'h48);
        send(8'h69);
        idle();
        chk("hi_cursor", bus.cursor, 2);
        chk("hi_dirty", bus.dirty, 1);
        push("hi", 1, 8'h69);
        push("hi", 0, 8'h48);
        for (int i = 2; i < 32; i++) push("hi_blank", i, 8'h20);
        drain(1);

        // 31 bytes then newline wraps cursor 31 -> 0
        do_reset();
        for (int i = 0; i < 31; i++) send(8'h61 + 8'(i % 26));
        idle();
        chk("nl31_pre", bus.cursor, 31);
        send(8'h0A);
        idle();
        chk("nl31_cursor", bus.cursor, 0);
        send(8'h58);
        idle();
        chk("x_cursor", bus.cursor, 1);
        push("x", 0, 8'h58);
        push("x", 1, 8'h62);
        push("x", 30, 8'h65);
        push("x", 31, 8'h20);
        drain(1);

        // newline from cursor 3 -> 16
        do_reset();
        send(8'h31); send(8'h32); send(8'h33);
        send(8'h0A);
        idle();
        chk("nl3_cursor", bus.cursor, 16);
        send(8'h59);
        idle();
        push("nl3", 16, 8'h59);
        push("nl3", 3, 8'h20);
        push("nl3", 2, 8'h33);
        drain(1);

        // backspace at 0 saturates
        do_reset();
        send(8'h08);
        idle();
        chk("bs0_cursor", bus.cursor, 0);
        chk("bs0_dirty", bus.dirty, 1);
        push("bs0", 0, 8'h20);
        drain(1);

        // backspace from 5
        do_reset();
        send(8'h61); send(8'h62); send(8'h63); send(8'h64); send(8'h65);
        send(8'h08);
        idle();
        chk("bs5_cursor", bus.cursor, 4);
        push("bs5", 4, 8'h20);
        push("bs5", 3, 8'h64);
        drain(1);

        // dirty_clr together with a printable byte: set wins
        do_reset();
        @(negedge clk);
        bus.dirty_clr = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data = 8'h41;
        @(posedge clk);
        #1;
        bus.dirty_clr = 1'b0;
        bus.wr_valid = 1'b0;
        chk("clr_vs_set_dirty", bus.dirty, 1);
        @(negedge clk);
        bus.dirty_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.dirty_clr = 1'b0;
        chk("clr_alone_dirty", bus.dirty, 0);
        send(8'h0A);
        idle();
        chk("nl_no_dirty", bus.dirty, 0);
        chk("nl1_cursor", bus.cursor, 16);
        send(8'h01);
        idle();
        chk("other_cursor", bus.cursor, 16);
        chk("other_dirty", bus.dirty, 0);
        bus.wr_data = 8'h51;
        @(posedge clk);
        #1;
        chk("novalid_cursor", bus.cursor, 16);
        push("other", 16, 8'h20);
        drain(1);

        // fill with 'A', then form feed with wr_valid held
        do_reset();
        for (int i = 0; i < 32; i++) send(8'h41);
        send(8'h0C);
        #1;
        bus.wr_data = 8'h5A;
        k = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            k++;
            chk("sweep_ready", bus.wr_ready, 0);
            if (k == 11) begin
                push("sweep10", 9, 8'h20);
                push("sweep10", 10, 8'h41);
                push("sweep10", 20, 8'h41);
                drain(0);
            end
        end
        bus.wr_valid = 1'b0;
        chk("sweep_len", k, 32);
        chk("sweep_cursor", bus.cursor, 0);
        chk("sweep_dirty", bus.dirty, 1);
        push_all("swept", 8'h20);
        drain(1);
        chk("sweep_ignored_cursor", bus.cursor, 0);

        // reset in the middle of a sweep
        do_reset();
        for (int i = 0; i < 32; i++) send(8'h41);
        send(8'h0C);
        idle();
        k = 1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            k++;
        end
        chk("mid_busy_pre", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_ready", bus.wr_ready, 0);
        chk("mid_cursor", bus.cursor, 0);
        chk("mid_dirty", bus.dirty, 0);
        push_all("mid_cell", 8'h20);
        drain(1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_ready_after", bus.wr_ready, 1);
        chk("mid_busy_after", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
